// File: rtl/scope_pkg.sv
// Shared types and constants for the trigger-and-capture stage behind the DDS generator.
package scope_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    READ      = 3'd4
  } state_e;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  localparam int DEF_DW = 10;
  localparam int DEF_AW = 10;

endpackage

// File: rtl/scope_if.sv
// Sample input stream and frame readout stream of the scope capture block.
interface scope_if #(parameter int DW = 10) ();
  logic          Sample_en;
  logic [DW-1:0] Sample_data;
  logic          Rd_valid;
  logic [DW-1:0] Rd_data;
  logic          Rd_ready;

  modport master (
    input  Sample_en, Sample_data, Rd_ready,
    output Rd_valid, Rd_data
  );

  modport slave (
    output Sample_en, Sample_data, Rd_ready,
    input  Rd_valid, Rd_data
  );
endinterface

// File: rtl/scope_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port, no reset.
module scope_ram #(
  parameter int DW = 10,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/scope_capture.sv
// Arms on command, waits for a level/slope trigger, captures one frame around it
// and replays it in order over a valid/ready stream.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Arm,
  input  logic          Abort,
  input  logic [DW-1:0] Trig_level,
  input  logic          Trig_slope,
  input  logic          Trig_auto,
  input  logic [AW-1:0] Pre_depth,
  output logic          Busy,
  output logic          Done,
  scope_if.master       bus
);

  localparam logic [AW:0]   NWORDS = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] LAST   = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] p_q, p_d;
  logic [DW-1:0] lvl_q, lvl_d;
  logic          slope_q, slope_d;
  logic          auto_q, auto_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW:0]   ld_cnt_q, ld_cnt_d;
  logic [AW:0]   acc_cnt_q, acc_cnt_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;

  logic          we;
  logic [DW-1:0] ram_q;
  logic          hit, accept, load;
  logic [DW-1:0] cur;

  assign cur    = bus.Sample_data;
  assign accept = vld_q && bus.Rd_ready;
  assign load   = (!vld_q || accept) && (ld_cnt_q != NWORDS);

  always_comb begin
    hit = 1'b0;
    if (auto_q)
      hit = 1'b1;
    else if (slope_q == SLOPE_RISE)
      hit = prev_vld_q && (prev_q < lvl_q) && (cur >= lvl_q);
    else
      hit = prev_vld_q && (prev_q > lvl_q) && (cur <= lvl_q);
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    lvl_d      = lvl_q;
    slope_d    = slope_q;
    auto_d     = auto_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    rd_addr_d  = rd_addr_q;
    ld_cnt_d   = ld_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    vld_d      = vld_q;
    data_d     = data_q;
    done_d     = 1'b0;
    we         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Arm) begin
          p_d        = Pre_depth;
          lvl_d      = Trig_level;
          slope_d    = Trig_slope;
          auto_d     = Trig_auto;
          wr_ptr_d   = '0;
          cnt_d      = Pre_depth;
          prev_vld_d = 1'b0;
          state_d    = (Pre_depth != '0) ? PRE : WAIT_TRIG;
        end
      end
      PRE: begin
        if (bus.Sample_en) begin
          we         = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          prev_d     = cur;
          prev_vld_d = 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == AW'(1)) state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (bus.Sample_en) begin
          we         = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          prev_d     = cur;
          prev_vld_d = 1'b1;
          if (hit) begin
            // Frame start is fixed here; the RAM read port pre-fetches it until READ.
            rd_addr_d = wr_ptr_q - p_q;
            cnt_d     = LAST - p_q;
            ld_cnt_d  = '0;
            acc_cnt_d = '0;
            state_d   = (p_q == LAST) ? READ : POST;
          end
        end
      end
      POST: begin
        if (bus.Sample_en) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == AW'(1)) state_d = READ;
        end
      end
      READ: begin
        if (accept) acc_cnt_d = acc_cnt_q + 1'b1;
        if (load) begin
          vld_d     = 1'b1;
          data_d    = ram_q;
          ld_cnt_d  = ld_cnt_q + 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end else if (accept) begin
          vld_d = 1'b0;
        end
        if (accept && acc_cnt_q == NWORDS - 1'b1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (Abort) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      p_q        <= '0;
      lvl_q      <= '0;
      slope_q    <= SLOPE_RISE;
      auto_q     <= 1'b0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rd_addr_q  <= '0;
      ld_cnt_q   <= '0;
      acc_cnt_q  <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      lvl_q      <= lvl_d;
      slope_q    <= slope_d;
      auto_q     <= auto_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      rd_addr_q  <= rd_addr_d;
      ld_cnt_q   <= ld_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  // Reading the next-state address keeps ram_q aligned with rd_addr_q under stalls.
  scope_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk_i   (Clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (cur),
    .raddr_i (rd_addr_d),
    .rdata_o (ram_q)
  );

  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign bus.Rd_valid = vld_q;
  assign bus.Rd_data  = data_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture with a 16-sample frame.
module tb_scope_capture;
  localparam int DW = 10;
  localparam int AW = 4;

  logic          Clk = 1'b0;
  logic          Rst_n, Arm, Abort, Trig_slope, Trig_auto, Busy, Done;
  logic [DW-1:0] Trig_level;
  logic [AW-1:0] Pre_depth;

  scope_if #(.DW(DW)) bus ();

  scope_capture #(.DW(DW), .AW(AW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Arm        (Arm),
    .Abort      (Abort),
    .Trig_level (Trig_level),
    .Trig_slope (Trig_slope),
    .Trig_auto  (Trig_auto),
    .Pre_depth  (Pre_depth),
    .Busy       (Busy),
    .Done       (Done),
    .bus        (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic slope;
    logic autot;
    int   level;
    int   pre;
    int   r0;      // first ramp sample after Arm
    int   rdir;    // ramp step
    int   rmask;   // ramp wrap mask
    int   rdymode; // 0: always ready, 1: ready pattern 1,0,0
    int   exp0;    // expected first readout word
  } vec_t;

  vec_t tbl [4];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int ramp(input vec_t t, input int i);
    return (t.r0 + t.rdir * i) & t.rmask;
  endfunction

  // Arm with record v, stream the ramp, check the readout.  stop_hs>0 returns
  // right after that many handshakes have been observed.
  task automatic frame(input int v, input int stop_hs);
    vec_t t;
    int k, i, cyc;
    logic hold, fin;
    logic [DW-1:0] hold_d;
    t = tbl[v];
    k = 0; i = 0; cyc = 0; hold = 1'b0; hold_d = '0; fin = 1'b0;
    @(posedge Clk); #1;
    Arm = 1'b1; Abort = 1'b0;
    Trig_slope = t.slope; Trig_auto = t.autot;
    Trig_level = DW'(t.level); Pre_depth = AW'(t.pre);
    bus.Sample_en = 1'b0; bus.Rd_ready = 1'b0;
    @(posedge Clk); #1;
    Arm = 1'b0;
    Trig_level = 10'd1023;  // later level changes must not matter
    bus.Sample_en = 1'b1; bus.Sample_data = DW'(ramp(t, i)); i++;
    bus.Rd_ready = (t.rdymode == 0) ? 1'b1 : 1'b1;
    @(negedge Clk);
    chk($sformatf("v%0d busy_rise", v), int'(Busy), 1);
    while (!fin && cyc < 300) begin
      if (hold) begin
        chk($sformatf("v%0d hold_valid", v), int'(bus.Rd_valid), 1);
        chk($sformatf("v%0d hold_data", v), int'(bus.Rd_data), int'(hold_d));
      end
      if (Done) begin
        chk($sformatf("v%0d done_count", v), k, 16);
        chk($sformatf("v%0d done_valid_low", v), int'(bus.Rd_valid), 0);
        chk($sformatf("v%0d done_busy_low", v), int'(Busy), 0);
        @(negedge Clk);
        chk($sformatf("v%0d done_single", v), int'(Done), 0);
        fin = 1'b1;
      end else begin
        if (bus.Rd_valid && bus.Rd_ready) begin
          chk($sformatf("v%0d word%0d", v, k), int'(bus.Rd_data),
              (t.exp0 + k) & t.rmask * 1 + 0 == 0 ? 0 : ((t.exp0 + t.rdir * k) & t.rmask));
          k++;
          hold = 1'b0;
          if (stop_hs > 0 && k == stop_hs) return;
        end else begin
          hold   = bus.Rd_valid;
          hold_d = bus.Rd_data;
        end
        @(posedge Clk); #1;
        cyc++;
        bus.Sample_data = DW'(ramp(t, i)); i++;
        bus.Rd_ready = (t.rdymode == 0) ? 1'b1 : ((cyc % 3) == 0);
        @(negedge Clk);
      end
    end
    if (!fin) chk($sformatf("v%0d timeout", v), cyc, -1);
  endtask

  initial begin
    int  dn;
    logic rv;
    // slope, auto, level, pre, r0, rdir, rmask, rdymode, exp0
    tbl[0] = '{1'b0, 1'b0, 5, 4,  0,  1, 1023, 0, 1};
    tbl[1] = '{1'b1, 1'b0, 8, 0, 15, -1,   15, 0, 8};
    tbl[2] = '{1'b0, 1'b1, 5, 15, 0,  1, 1023, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 5, 4,  0,  1, 1023, 1, 1};

    Rst_n = 1'b0; Arm = 1'b0; Abort = 1'b0; Trig_slope = 1'b0; Trig_auto = 1'b0;
    Trig_level = '0; Pre_depth = '0;
    bus.Sample_en = 1'b0; bus.Sample_data = '0; bus.Rd_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_valid", int'(bus.Rd_valid), 0);
    chk("rst_data", int'(bus.Rd_data), 0);

    for (int v = 0; v < 4; v++) frame(v, 0);

    // Trigger never reached: abort out of WAIT_TRIG.
    @(posedge Clk); #1;
    Arm = 1'b1; Trig_slope = 1'b0; Trig_auto = 1'b0; Trig_level = 10'd5; Pre_depth = 4'd2;
    bus.Sample_data = 10'd3; bus.Sample_en = 1'b0; bus.Rd_ready = 1'b1;
    rv = 1'b0; dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk); #1;
      Arm = 1'b0;
      bus.Sample_en = ((c % 3) == 2);
      @(negedge Clk);
      if (bus.Rd_valid) rv = 1'b1;
      if (Done) dn++;
    end
    chk("wait_busy", int'(Busy), 1);
    @(posedge Clk); #1 Abort = 1'b1;
    @(posedge Clk); #1 Abort = 1'b0;
    @(negedge Clk);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_valid", int'(bus.Rd_valid), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (Done) dn++;
      if (bus.Rd_valid) rv = 1'b1;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_valid", int'(rv), 0);

    // Arm with Abort in the same cycle stays idle.
    @(posedge Clk); #1 Arm = 1'b1; Abort = 1'b1;
    @(posedge Clk); #1 Arm = 1'b0; Abort = 1'b0;
    @(negedge Clk);
    chk("arm_abort_idle", int'(Busy), 0);

    frame(0, 0);

    // Reset in the middle of readout.
    frame(0, 5);
    @(posedge Clk); #1 Rst_n = 1'b0;
    @(posedge Clk); #1 Rst_n = 1'b1;
    @(negedge Clk);
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_done", int'(Done), 0);
    chk("midrst_valid", int'(bus.Rd_valid), 0);
    chk("midrst_data", int'(bus.Rd_data), 0);

    frame(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
Name: scope_capture

Overview:
- Trigger-and-capture stage directly downstream of the DDS generator in the UART scope design.
- Consumes the DDS 10-bit sample stream and arms on command.
- Waits for a level/slope trigger, then stores one frame of 2**AW samples, with the trigger sample at a programmable pre-trigger index.
- Replays the frame in order over a valid/ready word stream to the UART packing logic.

Parameters:
DW, 10, sample width (matches DDS output width)
AW, 10, frame address width; frame length N = 2**AW

Ports:
Clk  input  1  system clock
Rst_n  input  1  synchronous active-low reset, sampled on Clk rising edge
Sample_en  input  1  qualifies Sample_data for this cycle
Sample_data  input  DW  unsigned sample from DDS
Arm  input  1  one-cycle pulse: start a capture (honoured only in IDLE)
Abort  input  1  return to IDLE from any state
Trig_level  input  DW  unsigned trigger threshold
Trig_slope  input  1  0 = rising, 1 = falling
Trig_auto  input  1  1 = trigger on first WAIT_TRIG sample without a level test
Pre_depth  input  AW  samples kept before the trigger; latched on Arm
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse when the last frame word is accepted
Rd_valid  output  1  Rd_data is valid
Rd_data  output  DW  frame sample, index 0 first
Rd_ready  input  1  downstream accepts the word when Rd_valid && Rd_ready

Behaviour:
- Reset (Rst_n low at a Clk edge):
  - state = IDLE; Busy, Done, Rd_valid = 0; Rd_data = 0.
  - Write pointer, counters and prev_valid = 0.
  - RAM contents are not reset.
- Settings latch: on Arm in IDLE, latch Pre_depth→P, Trig_level, Trig_slope, Trig_auto; set wr_ptr = 0 and go to PRE if P > 0, else WAIT_TRIG. Busy rises the cycle after Arm.
- Sample acceptance: only Sample_en cycles write RAM[wr_ptr]; wr_ptr then increments mod N.
- prev_sample/prev_valid update on every accepted sample in PRE and WAIT_TRIG.
- PRE: accept exactly P samples, then WAIT_TRIG. The WAIT_TRIG entry cycle writes nothing extra.
- WAIT_TRIG:
  - Keep writing circularly.
  - Rising trigger: prev_valid && prev_sample < level && cur >= level.
  - Falling trigger: prev_valid && prev_sample > level && cur <= level.
  - Auto: the first accepted sample triggers.
  - The triggering sample is written; trig_addr = its address. Go to POST with post_cnt = N-1-P.
- POST:
  - Accept post_cnt more samples, then READ.
  - If post_cnt = 0 (P = N-1), go directly to READ the cycle after the trigger.
- READ:
  - Sample_en is ignored.
  - Read address starts at (trig_addr - P) mod N and increments mod N.
  - RAM read is synchronous (1-cycle latency). The first Rd_valid asserts no later than 2 cycles after entering READ.
  - Rd_data/Rd_valid are registered and held stable while Rd_valid && !Rd_ready.
  - Full throughput (one word per cycle) when Rd_ready is held high.
  - After N words are accepted: Done pulses for 1 cycle (same cycle Rd_valid drops) and state = IDLE.
- Arm outside IDLE is ignored. Arm and Abort in the same cycle: Abort wins.
- Abort from any state: the next state is IDLE, Rd_valid drops next cycle, and Done is not pulsed.
- Reset mid-operation behaves identically to Abort, plus full output reset.
- Comparisons are unsigned, DW bits. Trig_level change after Arm has no effect.
- Frame never contains stale RAM from a previous capture: P pre samples plus the trigger plus N-1-P post samples = N fresh writes.

Decomposition:
- Package scope_pkg:
  - State encoding IDLE/PRE/WAIT_TRIG/POST/READ (3-bit).
  - SLOPE_RISE = 0, SLOPE_FALL = 1.
  - Default DW/AW constants.
- Sub-module scope_ram: simple dual-port N×DW RAM, one write port, one synchronous-read port, no reset. It is inferable as block RAM.

Test Plan (bench uses AW=4, N=16; Sample_en every cycle unless stated):
- Rising, P=4, level=5, ramp 0,1,2…:
  - Trigger fires on sample 5.
  - Readout = 1..16; Done pulses once; Busy low after.
- Falling, P=0, level=8, ramp down from 15:
  - Trigger fires on 8.
  - Readout = 8,7,…,0,15,14,… per the input (first word 8).
  - P=0 path skips PRE.
- Trig_auto=1, P=15, ramp from 0:
  - Trigger fires on sample 15; post_cnt = 0.
  - Readout = 0..15; POST bypassed.
- Backpressure: rising P=4 case with Rd_ready toggling 1,0,0,1…:
  - Each word is held stable while unaccepted.
  - Readout sequence is unchanged; exactly 16 handshakes; Done on the 16th.
- Sample_en every third cycle, level never crossed (constant 3, level=5):
  - Busy stays high in WAIT_TRIG.
  - Abort → IDLE next cycle, no Done, Rd_valid never asserted.
  - A new Arm then works.
- Rst_n low for 1 cycle during READ (after 5 words):
  - All outputs 0 next cycle; state IDLE.
  - A subsequent Arm runs a full correct capture.
